// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write-side arbiter: the two-state FSM
// encoding and the default per-tenure burst length.
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int BURST_DEFAULT = 4;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first set request at or
// after rr_ptr, scanning upward and wrapping from NREQ-1 back to 0.
//
// Ports
//   req     in   NREQ  request vector
//   rr_ptr  in   PW    scan start index
//   found   out  1     at least one request is set
//   idx     out  PW    index of the selected request (0 when none)
// ---------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic            found,
    output logic [PW-1:0]   idx
);

    localparam int SW = PW + 1;

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   rot;
    logic [SW-1:0]     sum;

    always_comb begin
        // Rotate so that bit 0 of rot corresponds to index rr_ptr; the
        // doubled copy supplies the wrapped-around upper indices.
        req_dbl = {req, req} >> rr_ptr;
        rot     = req_dbl[NREQ-1:0];
        found   = |rot;
        sum     = '0;
        // Walk downward so the lowest set offset wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, rr_ptr} + SW'(k);
            end
        end
        if (sum >= SW'(NREQ)) begin
            sum = sum - SW'(NREQ);
        end
        idx = sum[PW-1:0];
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb
// Shares one FIFO write port among NREQ requesters. An idle cycle picks the
// next owner round-robin; the owner then writes up to BURST words, stalling
// on wfull and yielding early on wfull_almost or when its request drops.
//
// Ports
//   wclk          in   1            write-domain clock
//   wrst_n        in   1            asynchronous active-low reset
//   req           in   NREQ         per-requester word available
//   req_data      in   NREQ*DSIZE   requester i word on [i*DSIZE +: DSIZE]
//   gnt           out  NREQ         one-hot: requester's word written now
//   wdata         out  DSIZE        FIFO write data
//   winc          out  1            FIFO write enable
//   wfull         in   1            FIFO full
//   wfull_almost  in   1            FIFO almost full
//   owner         out  clog2(NREQ)  current owner, 0 when idle
//   busy          out  1            high while an owner holds the port
// ---------------------------------------------------------------------------
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int DSIZE = 12,
    parameter int NREQ  = 4,
    parameter int BURST = BURST_DEFAULT
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    output logic [NREQ-1:0]         gnt,
    output logic [DSIZE-1:0]        wdata,
    output logic                    winc,
    input  logic                    wfull,
    input  logic                    wfull_almost,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    arb_state_t    state;
    logic [OW-1:0] rr_ptr;
    logic [OW-1:0] own_q;
    logic [CW-1:0] burst_cnt;

    logic          found;
    logic [OW-1:0] pick_idx;
    logic          own_req;
    logic          wr;
    logic          last_word;
    logic [OW-1:0] next_ptr;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (OW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (found),
        .idx    (pick_idx)
    );

    always_comb begin
        own_req   = req[own_q];
        // wfull gates the write itself, so it also blocks the almost-full exit.
        wr        = (state == OWN) && own_req && !wfull;
        last_word = (burst_cnt == CW'(BURST - 1)) || wfull_almost;
        next_ptr  = (own_q == OW'(NREQ - 1)) ? '0 : own_q + 1'b1;
    end

    // The write path is combinational off the owner register so a word can
    // be accepted in the same cycle the requester presents it.
    always_comb begin
        winc  = wr;
        gnt   = wr ? (NREQ'(1) << own_q) : '0;
        wdata = (state == OWN) ? req_data[own_q*DSIZE +: DSIZE] : '0;
        owner = (state == OWN) ? own_q : '0;
        busy  = (state == OWN);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            own_q     <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        own_q     <= pick_idx;
                        burst_cnt <= '0;
                        state     <= OWN;
                    end
                end
                OWN: begin
                    if (!own_req) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end else if (wr) begin
                        burst_cnt <= burst_cnt + CW'(1);
                        if (last_word) begin
                            state  <= IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DSIZE, default 12: word width, equal to the DSIZE of the write-side FIFO being shared.
REQ-002 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-003 Parameter BURST, default 4: maximum words one owner writes per tenure, 1..16.
REQ-004 wclk  in  1: the block's only clock, the FIFO write-domain clock.
REQ-005 wrst_n  in  1: asynchronous active-low reset.
REQ-006 req  in  NREQ: per-requester "word available", held until granted.
REQ-007 req_data  in  NREQ*DSIZE: requester i's word on bits [i*DSIZE +: DSIZE].
REQ-008 gnt  out  NREQ: one-hot; a pulse means that requester's word was written this cycle.
REQ-009 wdata  out  DSIZE: write data to the FIFO.
REQ-010 winc  out  1: FIFO write enable.
REQ-011 wfull  in  1: FIFO full flag, wclk domain.
REQ-012 wfull_almost  in  1: FIFO almost-full flag, wclk domain.
REQ-013 owner  out  $clog2(NREQ): index of the current owner; 0 when idle.
REQ-014 busy  out  1: high while in state OWN.

Function
REQ-015 The FSM shall have two states, IDLE and OWN, with registered rr_ptr, owner and burst_cnt.
REQ-016 In IDLE with any req set, the block shall pick the first set req at or after rr_ptr, scanning upward with wrap, and register it as owner; the next state is OWN, and no write occurs in this cycle (one-cycle arbitration latency).
REQ-017 In IDLE, winc and gnt shall be 0, and wdata shall be 0.
REQ-018 In OWN, the write outputs are combinational: winc = req[owner] & ~wfull, gnt[owner] = winc, wdata = req_data[owner].
REQ-019 Each write in OWN shall increment burst_cnt; burst_cnt shall be cleared on every entry to OWN.
REQ-020 OWN shall end, returning to IDLE with rr_ptr = (owner+1) mod NREQ, when either:
 - req[owner] is 0, or
 - a write occurs with burst_cnt == BURST-1, or
 - a write occurs while wfull_almost = 1.
REQ-021 When wfull = 1 in OWN with req[owner] = 1, the block shall stall in OWN: no write, no count change, no rotation.
REQ-022 When wfull and wfull_almost are both 1, wfull shall take precedence: stall, no exit.
REQ-023 A requester dropping req without a grant shall lose no data and shall cause no gnt.
REQ-024 The wrap from index NREQ-1 to index 0 shall hold for both rr_ptr and the scan.
REQ-025 The block shall never assert winc while wfull = 1.
REQ-026 With all req held and wfull = 0, the block shall write exactly BURST words per owner, with one idle cycle between tenures.

Reset
REQ-027 While wrst_n = 0, asynchronously: state = IDLE, rr_ptr = 0, owner = 0, burst_cnt = 0, winc = 0, gnt = 0, wdata = 0, busy = 0.
REQ-028 Reset asserted mid-burst shall deassert winc immediately; the partial burst shall not resume after release.
REQ-029 The first arbitration after reset release shall start its scan at index 0.

Structure
REQ-030 Package fifo_arb_pkg shall hold the state enum (IDLE, OWN) and the default BURST constant.
REQ-031 Sub-module rr_pick shall contain the combinational round-robin picker:
 - inputs: req, rr_ptr
 - outputs: found, idx

Verification (NREQ=4, BURST=4, DSIZE=12)
REQ-032 All req=4'b1111, wfull=0, rr_ptr=0 after reset -> owner sequence 0,1,2,3,0; 4 gnt pulses each; one winc-low cycle between tenures.
REQ-033 req[2] only, word 12'hA5C, wfull=0 -> IDLE one cycle, then winc=1, wdata=12'hA5C, gnt=4'b0100.
REQ-034 Owner 1 mid-burst; wfull raised for 3 cycles -> winc=0 for those 3 cycles, burst_cnt held, owner stays 1, burst completes to 4 words after wfull falls.
REQ-035 Owner 0 with req=4'b1001 and wfull_almost=1 at its first write -> exactly 1 word written, then next owner is 3.
REQ-036 Reset pulsed during the third word of a burst -> winc low during reset; after release, owner 0 is selected first and burst_cnt restarts at 0.
REQ-037 Random req with random wfull/wfull_almost, 10k cycles -> no winc while wfull=1; gnt one-hot or zero; per-requester grant counts within BURST of each other under saturation.
